systolic_skew_feeder: RTL

//  Upstream feed stage for the 4x4 systolic multiply array. Captures operand matrices A, B via valid/ready,

---
 rtl/systolic_skew_feeder_pkg.sv | 28 ++
 rtl/systolic_skew_feeder_if.sv | 36 +++
 rtl/systolic_skew_feeder_skew_lane.sv | 55 +++++
 rtl/systolic_skew_feeder.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/systolic_skew_feeder_pkg.sv
// ---------------------------------------------------------------------------
// systolic_pkg
//   Shared sizes and types for the 4x4 systolic feed stage.
//   N     : array dimension (rows = cols = N)
//   W     : operand element width in bits
//   CNT_W : step counter width, must be able to hold 3N-1
//   IDX_W : bits needed to select one of N elements
//   elem_t / lane_t / mat_t : element, one edge (N lanes), full N x N matrix.
//   mat_t is packed row-major, so element [r][c] sits at bit (r*N+c)*W.
//   feeder_state_e : readable view of the feeder FSM for debug ports.
// ---------------------------------------------------------------------------
package systolic_pkg;
  localparam int N     = 4;
  localparam int W     = 8;
  localparam int CNT_W = 4;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef logic [W-1:0]          elem_t;
  typedef elem_t [N-1:0]         lane_t;
  typedef elem_t [N-1:0][N-1:0]  mat_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    FEED  = 2'd2,
    DRAIN = 2'd3
  } feeder_state_e;
endpackage

// File: rtl/systolic_skew_feeder_if.sv
// ---------------------------------------------------------------------------
// systolic_skew_feeder_if
//   Bundles the operand-load handshake and the array-side edge outputs.
//   Signals:
//     load_valid   : producer has matrix_a/matrix_b valid this cycle
//     load_ready   : feeder can accept a load (only while idle)
//     matrix_a/b   : operand matrices, row-major packed (mat_t)
//     a_edge/b_edge: west / north edge lanes into the array
//     elem_clear_n : active-low accumulator clear to every array element
//     busy, done   : status; done is a one-cycle completion pulse
//   Handshake: a load transfers on a rising clock edge where load_valid and
//   load_ready are both 1. load_valid is ignored while load_ready is 0, and
//   matrix_a/matrix_b only need to be stable in the transfer cycle.
//   Modports: master = operand producer / observer, slave = the feeder.
// ---------------------------------------------------------------------------
interface systolic_skew_feeder_if;
  logic               load_valid;
  logic               load_ready;
  systolic_pkg::mat_t matrix_a;
  systolic_pkg::mat_t matrix_b;
  systolic_pkg::lane_t a_edge;
  systolic_pkg::lane_t b_edge;
  logic               elem_clear_n;
  logic               busy;
  logic               done;

  modport master (
    output load_valid, matrix_a, matrix_b,
    input  load_ready, a_edge, b_edge, elem_clear_n, busy, done
  );

  modport slave (
    input  load_valid, matrix_a, matrix_b,
    output load_ready, a_edge, b_edge, elem_clear_n, busy, done
  );
endinterface

// File: rtl/systolic_skew_feeder_skew_lane.sv
// ---------------------------------------------------------------------------
// skew_lane
//   One edge lane of the feeder. Selects element (step - L) of its N captured
//   operands while the step lies in the lane's window [L, L+N), otherwise
//   emits zero, and registers the result.
//   Parameter L : lane offset (diagonal skew) of this lane.
//   Ports:
//     clock, reset : rising-edge clock, synchronous active-low reset
//     elems_i      : the N operands this lane walks through, index k = 0..N-1
//     feed_i       : the next cycle is a FEED cycle
//     step_i       : the step value of the next cycle
//     edge_o       : registered lane output (value for the current step)
// ---------------------------------------------------------------------------
module skew_lane
  import systolic_pkg::*;
#(
  parameter int L = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  lane_t            elems_i,
  input  logic             feed_i,
  input  logic [CNT_W-1:0] step_i,
  output elem_t            edge_o
);
  localparam logic [CNT_W-1:0] L_C = CNT_W'(L);
  localparam logic [CNT_W-1:0] N_C = CNT_W'(N);

  logic             borrow;
  logic [CNT_W-1:0] idx;
  logic             in_win;
  elem_t            edge_d;
  elem_t            edge_q;

  // step - L in CNT_W bits; the borrow bit says step < L (before the window).
  assign {borrow, idx} = {1'b0, step_i} - {1'b0, L_C};
  assign in_win        = feed_i && !borrow && (idx < N_C);

  always_comb begin
    edge_d = '0;
    if (in_win) begin
      edge_d = elems_i[idx[IDX_W-1:0]];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      edge_q <= '0;
    end else begin
      edge_q <= edge_d;
    end
  end

  assign edge_o = edge_q;
endmodule

// File: rtl/systolic_skew_feeder.sv
// ---------------------------------------------------------------------------
// systolic_skew_feeder
//   Feed stage for the N x N systolic multiply array. Captures A and B over a
//   valid/ready load, clears the array accumulators for one cycle, then
//   streams A rows onto the west edge and B columns onto the north edge with
//   a one-cycle-per-lane diagonal skew and zero padding.
//   FSM: IDLE -> CLEAR -> FEED (2N-1 steps) -> [DRAIN (N cycles)] -> IDLE.
//   done pulses in the first IDLE cycle; a load in that cycle starts the next
//   job with no bubble.
//   Build option: SKEW_FEEDER_DRAIN_EN adds the DRAIN state so done is only
//   raised once the last array element holds its final sum.
//   Ports:
//     clock       : rising-edge clock
//     reset       : synchronous active-low reset (aborts any job, no done)
//     bus         : systolic_skew_feeder_if.slave (load + edge outputs)
//     dbg_state_o : current FSM state
//   Every output comes straight from a register.
// ---------------------------------------------------------------------------
module systolic_skew_feeder
  import systolic_pkg::*;
(
  input  logic                         clock,
  input  logic                         reset,
  systolic_skew_feeder_if.slave        bus,
  output feeder_state_e                dbg_state_o
);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_FEED  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  localparam logic [CNT_W-1:0] LAST_FEED  = CNT_W'(2*N-2);
  localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(N-1);

  if ((3*N-1) >= (1 << CNT_W)) begin : g_cnt_w_check
    $error("CNT_W is too narrow to hold 3N-1");
  end

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] step_q, step_d;
  logic             capture;
  logic             done_d;
  logic             feed_d;
  mat_t             a_q, b_q;
  logic             load_ready_q;
  logic             busy_q;
  logic             clear_n_q;
  logic             done_q;
  lane_t            a_edge_w, b_edge_w;
  lane_t            b_col [N];

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    capture = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.load_valid) begin
          capture = 1'b1;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        state_d = ST_FEED;
        step_d  = '0;
      end
      ST_FEED: begin
        if (step_q == LAST_FEED) begin
          step_d = '0;
`ifdef SKEW_FEEDER_DRAIN_EN
          state_d = ST_DRAIN;
`else
          state_d = ST_IDLE;
          done_d  = 1'b1;
`endif
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (step_q == LAST_DRAIN) begin
          step_d  = '0;
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        step_d  = '0;
      end
    endcase
  end

  // Lanes register the value for the *next* step so the port shows step s
  // during the cycle in which step_q == s.
  assign feed_d = (state_d == ST_FEED);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      step_q       <= '0;
      load_ready_q <= 1'b1;
      busy_q       <= 1'b0;
      clear_n_q    <= 1'b1;
      done_q       <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      load_ready_q <= (state_d == ST_IDLE);
      busy_q       <= (state_d != ST_IDLE);
      clear_n_q    <= (state_d != ST_CLEAR);
      done_q       <= done_d;
      if (capture) begin
        a_q <= bus.matrix_a;
        b_q <= bus.matrix_b;
      end
    end
  end

  // Column j of B, element k = B[k][j], feeds north lane j.
  for (genvar j = 0; j < N; j++) begin : g_b_col
    for (genvar k = 0; k < N; k++) begin : g_b_elem
      assign b_col[j][k] = b_q[k][j];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lanes
    skew_lane #(.L(i)) u_a_lane (
      .clock   (clock),
      .reset   (reset),
      .elems_i (a_q[i]),
      .feed_i  (feed_d),
      .step_i  (step_d),
      .edge_o  (a_edge_w[i])
    );
    skew_lane #(.L(i)) u_b_lane (
      .clock   (clock),
      .reset   (reset),
      .elems_i (b_col[i]),
      .feed_i  (feed_d),
      .step_i  (step_d),
      .edge_o  (b_edge_w[i])
    );
  end

  assign bus.load_ready   = load_ready_q;
  assign bus.busy         = busy_q;
  assign bus.elem_clear_n = clear_n_q;
  assign bus.done         = done_q;
  assign bus.a_edge       = a_edge_w;
  assign bus.b_edge       = b_edge_w;
  assign dbg_state_o      = feeder_state_e'(state_q);
endmodule
